// File: rtl/sr_pulse_driver.sv
// Drives the S/R inputs of an asynchronous SR latch with fixed-width, non-overlapping
// pulses, a dead-time gap, and a readback check of the latch output afterwards.
module sr_pulse_driver #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic clr_req,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic done,
  output logic q_exp,
  output logic conflict,
  output logic fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET_P = 3'd1,
    CLR_P = 3'd2,
    GAP   = 3'd3,
    CHECK = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             q_exp_q, q_exp_d;
  logic             conflict_q, conflict_d;
  logic             fault_q, fault_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    q_exp_d    = q_exp_q;
    fault_d    = fault_q;
    conflict_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (set_req && clr_req) begin
          conflict_d = 1'b1;
        end else if (set_req) begin
          state_d = SET_P;
          cnt_d   = PULSE_LOAD;
          q_exp_d = 1'b1;
        end else if (clr_req) begin
          state_d = CLR_P;
          cnt_d   = PULSE_LOAD;
          q_exp_d = 1'b0;
        end
      end
      SET_P, CLR_P: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CHECK: begin
        // q_fb has had the whole gap to settle, so it is sampled without a synchronizer
        if (q_fb != q_exp_q) begin
          fault_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave a flop with no glitches
    s_d    = (state_d == SET_P);
    r_d    = (state_d == CLR_P);
    busy_d = (state_d != IDLE);
    done_d = (state_d == CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      q_exp_q    <= 1'b0;
      conflict_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      q_exp_q    <= q_exp_d;
      conflict_q <= conflict_d;
      fault_q    <= fault_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign q_exp    = q_exp_q;
  assign conflict = conflict_q;
  assign fault    = fault_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Bench for sr_pulse_driver: two instances (4/2 and 1/1 timing) each driving a latch model,
// checked every cycle against a phase-count reference model plus literal expectations.
module tb_sr_pulse_driver;

  localparam int P0 = 4, G0 = 2;
  localparam int P1 = 1, G1 = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] set_r = '0, clr_r = '0, stuck = '0;
  logic [1:0] q_fb, s_o, r_o, busy, done, q_exp, conflict, fault;
  logic       lq0 = 1'b0, lq1 = 1'b0;
  logic       cmp_en = 1'b0;
  int         checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sr_pulse_driver #(.PULSE_CYCLES(P0), .GAP_CYCLES(G0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .set_req(set_r[0]), .clr_req(clr_r[0]), .q_fb(q_fb[0]),
    .S(s_o[0]), .R(r_o[0]), .busy(busy[0]), .done(done[0]), .q_exp(q_exp[0]),
    .conflict(conflict[0]), .fault(fault[0]));

  sr_pulse_driver #(.PULSE_CYCLES(P1), .GAP_CYCLES(G1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .set_req(set_r[1]), .clr_req(clr_r[1]), .q_fb(q_fb[1]),
    .S(s_o[1]), .R(r_o[1]), .busy(busy[1]), .done(done[1]), .q_exp(q_exp[1]),
    .conflict(conflict[1]), .fault(fault[1]));

  // Asynchronous SR latch models; stuck forces the readback to 0
  always @(s_o[0] or r_o[0]) begin
    if (s_o[0]) lq0 = 1'b1;
    else if (r_o[0]) lq0 = 1'b0;
  end
  always @(s_o[1] or r_o[1]) begin
    if (s_o[1]) lq1 = 1'b1;
    else if (r_o[1]) lq1 = 1'b0;
  end
  assign q_fb[0] = stuck[0] ? 1'b0 : lq0;
  assign q_fb[1] = stuck[1] ? 1'b0 : lq1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_ph counts cycles since the accepting edge (0 = idle)
  int   m_ph [2];
  logic m_cmd [2], m_qexp [2], m_fault [2], m_conf [2];

  function automatic int pc(input int i); return (i == 0) ? P0 : P1; endfunction
  function automatic int gc(input int i); return (i == 0) ? G0 : G1; endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_ph[i] = 0; m_cmd[i] = 1'b0; m_qexp[i] = 1'b0; m_fault[i] = 1'b0; m_conf[i] = 1'b0;
      end else begin
        m_conf[i] = 1'b0;
        if (m_ph[i] == 0) begin
          if (set_r[i] && clr_r[i]) m_conf[i] = 1'b1;
          else if (set_r[i]) begin m_ph[i] = 1; m_cmd[i] = 1'b1; m_qexp[i] = 1'b1; end
          else if (clr_r[i]) begin m_ph[i] = 1; m_cmd[i] = 1'b0; m_qexp[i] = 1'b0; end
        end else if (m_ph[i] == pc(i) + gc(i) + 1) begin
          if (q_fb[i] !== m_qexp[i]) m_fault[i] = 1'b1;
          m_ph[i] = 0;
        end else begin
          m_ph[i] = m_ph[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 2; i++) begin
        logic in_pulse;
        in_pulse = (m_ph[i] >= 1) && (m_ph[i] <= pc(i));
        chk($sformatf("ch%0d S", i), s_o[i], in_pulse && m_cmd[i]);
        chk($sformatf("ch%0d R", i), r_o[i], in_pulse && !m_cmd[i]);
        chk($sformatf("ch%0d busy", i), busy[i], m_ph[i] != 0);
        chk($sformatf("ch%0d done", i), done[i], m_ph[i] == pc(i) + gc(i) + 1);
        chk($sformatf("ch%0d conflict", i), conflict[i], m_conf[i]);
        chk($sformatf("ch%0d q_exp", i), q_exp[i], m_qexp[i]);
        chk($sformatf("ch%0d fault", i), fault[i], m_fault[i]);
      end
    end
  end

  task automatic wait_idle(input int i);
    for (int k = 0; k < 50 && busy[i]; k++) @(negedge clk);
    if (busy[i]) chk($sformatf("ch%0d idle timeout", i), busy[i], 0);
  endtask

  // Pulses one request on ch0 and tallies S/R/busy/done cycles over the next 12 cycles
  task automatic pulse_count(input logic is_set, output int ns, output int nr, output int nb, output int nd);
    if (is_set) set_r[0] = 1'b1; else clr_r[0] = 1'b1;
    @(negedge clk);
    set_r[0] = 1'b0; clr_r[0] = 1'b0;
    ns = 0; nr = 0; nb = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (s_o[0]) ns++;
      if (r_o[0]) nr++;
      if (busy[0]) nb++;
      if (done[0]) nd++;
      @(negedge clk);
    end
  endtask

  initial begin
    int ns, nr, nb, nd, last;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("reset S", s_o[0], 0);
    chk("reset busy", busy[0], 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle S/R", {s_o, r_o}, 0);
    chk("idle q_exp/fault", {q_exp, fault}, 0);

    // Single set command
    pulse_count(1'b1, ns, nr, nb, nd);
    chk("set S cycles", ns, 4);
    chk("set R cycles", nr, 0);
    chk("set busy cycles", nb, 7);
    chk("set done cycles", nd, 1);
    chk("set q_exp", q_exp[0], 1);
    chk("set fault", fault[0], 0);

    // Both requests while idle
    set_r[0] = 1'b1; clr_r[0] = 1'b1;
    @(negedge clk);
    set_r[0] = 1'b0; clr_r[0] = 1'b0;
    chk("conflict pulse", conflict[0], 1);
    chk("conflict busy", busy[0], 0);
    chk("conflict q_exp", q_exp[0], 1);
    @(negedge clk);
    chk("conflict one cycle", conflict[0], 0);

    // Requests during busy are dropped
    set_r[0] = 1'b1;
    @(negedge clk);
    set_r[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      clr_r[0] = (k == 1 || k == 4);
      @(negedge clk);
    end
    clr_r[0] = 1'b0;
    wait_idle(0);
    chk("dropped q_exp", q_exp[0], 1);
    pulse_count(1'b0, ns, nr, nb, nd);
    chk("clr R cycles", nr, 4);
    chk("clr S cycles", ns, 0);
    chk("clr q_exp", q_exp[0], 0);

    // Stuck-at-0 readback sets a sticky fault
    stuck[0] = 1'b1;
    set_r[0] = 1'b1;
    @(negedge clk);
    set_r[0] = 1'b0;
    for (int k = 0; k < 50 && !done[0]; k++) @(negedge clk);
    chk("stuck fault before check edge", fault[0], 0);
    wait_idle(0);
    chk("stuck fault set", fault[0], 1);
    stuck[0] = 1'b0;
    pulse_count(1'b0, ns, nr, nb, nd);
    chk("fault sticky", fault[0], 1);
    chk("fault sticky q_exp", q_exp[0], 0);

    // Reset in the middle of a set pulse
    set_r[0] = 1'b1;
    @(negedge clk);
    set_r[0] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset S", s_o[0], 0);
    chk("async reset busy", busy[0], 0);
    chk("async reset fault", fault[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("after reset fault", fault[0], 0);

    // Alternating commands at full rate on the 1/1 instance
    last = 0;
    for (int c = 0; c < 8; c++) begin
      if (c % 2 == 0) set_r[1] = 1'b1; else clr_r[1] = 1'b1;
      @(negedge clk);
      set_r[1] = 1'b0; clr_r[1] = 1'b0;
      chk("fast accepted", busy[1], 1);
      chk("fast q_exp", q_exp[1], (c % 2 == 0));
      if (c > 0) chk("fast period", cyc - last, 4);
      last = cyc;
      nb = 0;
      for (int k = 0; k < 10 && busy[1]; k++) begin
        nb++;
        @(negedge clk);
      end
      chk("fast busy cycles", nb, 3);
    end

    // Randomized traffic with occasional stuck readback and resets
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        set_r[i] = ($urandom_range(0, 3) == 0);
        clr_r[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 39) == 0) stuck = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    set_r = '0; clr_r = '0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
